sub_chunk_seq: RTL and testbench
================================

Name: sub_chunk_seq

Overview:
Parametrised multi-cycle adder/subtractor. It is the successor to the fixed 8-bit gate-level ripple-borrow subtractor.
- Operands are WIDTH bits wide and are processed CHUNK bits per clock, LSB chunk first. Borrow/carry is held in a register between chunks.
- Start/busy/done handshake; add/subtract selected per operation.
- Sits between the operand registers and the result bus of the datapath, where a full-width single-cycle ripple chain misses timing.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2.
CHUNK, 2, bits processed per cycle; must divide WIDTH exactly. Elaboration error otherwise.
NCHUNK, WIDTH/CHUNK, derived localparam; number of processing cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  1 = A-B-bin, 0 = A+B+bin; latched on accepted start
A  input  WIDTH  minuend/addend; latched on accepted start
B  input  WIDTH  subtrahend/addend; latched on accepted start
bin  input  1  borrow-in (sub) or carry-in (add); latched on accepted start
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result is valid
diff  output  WIDTH  result register
bout  output  1  borrow-out (sub) or carry-out (add)

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, bout=0; chunk counter=0; internal A/B/mode/borrow registers=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge: latch A, B, sub, bin into internal registers; counter=0; go to RUN. If start=0, stay.
- RUN: one chunk per edge, index = counter.
  - Slice k = bits [k*CHUNK +: CHUNK].
  - Compute slice result with the registered borrow/carry.
  - Write the slice result into diff[k*CHUNK +: CHUNK]; update the borrow register; counter++.
  - After the edge processing chunk NCHUNK-1, go to DONE.
  - start is ignored during RUN; input changes do not affect the result.
- DONE: done=1 and busy=0 for exactly this cycle. bout = final borrow/carry.
  - start=1 at this edge: accepted as in IDLE (back-to-back) and goes to RUN.
  - Otherwise go to IDLE.
- Latency: start sampled at edge 0 → done high after edge NCHUNK, i.e. NCHUNK cycles. Throughput: one op per NCHUNK+1 cycles.
- diff and bout hold their last value until the next accepted start. diff is updated chunk-wise during RUN, so it is valid only when done=1 or in IDLE afterwards.
- Arithmetic is unsigned modulo 2^WIDTH.
  - sub=1: bout=1 iff A < B+bin.
  - sub=0: bout=1 iff A+B+bin ≥ 2^WIDTH.
- CHUNK=WIDTH is legal: single RUN cycle, latency 1.
- Reset asserted mid-RUN aborts the operation; no done pulse follows.

Optional Feature:
SUB_CHUNK_SEQ_FLAGS_EN.
- Defined: adds three outputs, each 1-bit and registered, valid with done and held afterwards; reset 0.
  - zf = (diff==0).
  - nf = diff[WIDTH-1].
  - vf = signed two's-complement overflow of the operation.
    - sub: A, B signs differ and result sign ≠ A sign.
    - add: A, B signs equal and result sign ≠ A sign.
- Undefined: ports and logic absent; all other behaviour unchanged.

Decomposition:
- Package sub_chunk_seq_pkg:
  - state enum (IDLE, RUN, DONE);
  - mode constants MODE_ADD=0, MODE_SUB=1.
- Sub-module sub_slice: combinational CHUNK-bit ripple cell.
  - Inputs: a, b, borrow/carry-in, mode.
  - Outputs: result, borrow/carry-out.
  - Generalised per-bit xor/and/or borrow cell; instantiated once in sub_chunk_seq.

Test Plan:
1. WIDTH=8, CHUNK=2, sub=1, A=0x5A, B=0x3C, bin=0 → after 4 cycles done=1, diff=0x1E, bout=0; busy high for exactly 4 cycles.
2. sub=1, A=0x00, B=0x01, bin=0 → diff=0xFF, bout=1; with flags: zf=0, nf=1, vf=0.
3. sub=1, A=0x80, B=0x7F, bin=1 → diff=0x00, bout=0; flags zf=1, nf=0, vf=1.
4. sub=0, A=0xFF, B=0x01, bin=0 → diff=0x00, bout=1. Then start=1 in the DONE cycle with A=0x10, B=0x20, sub=0 → accepted, diff=0x30, bout=0.
5. start pulsed again and A changed during RUN → ignored, original result delivered. rst asserted mid-RUN → immediately busy=0, diff=0, no done pulse. Next start completes normally.
6. WIDTH=16, CHUNK=16: sub=1, A=0x1234, B=0x1235 → done after 1 cycle, diff=0xFFFF, bout=1. Random sweep over WIDTH=12, CHUNK=3 against a reference model.

Source files
------------

// File: rtl/sub_chunk_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk_seq_pkg
// Purpose  : Shared types and constants for the chunked add/subtract unit.
//            state_t  - sequencer states (IDLE, RUN, DONE)
//            MODE_*   - encoding of the per-operation add/subtract select
// Revision : 1.0 - initial release
// ============================================================================
package sub_chunk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sub_chunk_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk_seq_if
// Purpose  : Operation request / result bundle for sub_chunk_seq.
//            master : start, sub, A, B, bin  ->   busy, done, diff, bout  <-
//            slave  : the mirror image (used by the arithmetic unit)
//            With SUB_CHUNK_SEQ_FLAGS_EN defined the result side also
//            carries the zf / nf / vf status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface sub_chunk_seq_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_CHUNK_SEQ_FLAGS_EN
  logic             zf;
  logic             nf;
  logic             vf;
`endif

  modport master (
    output start, sub, A, B, bin,
    input  busy, done, diff, bout
`ifdef SUB_CHUNK_SEQ_FLAGS_EN
    , input zf, nf, vf
`endif
  );

  modport slave (
    input  start, sub, A, B, bin,
    output busy, done, diff, bout
`ifdef SUB_CHUNK_SEQ_FLAGS_EN
    , output zf, nf, vf
`endif
  );

endinterface
`default_nettype wire

// File: rtl/sub_slice.sv
`default_nettype none
// ============================================================================
// Module   : sub_slice
// Purpose  : Combinational CHUNK-bit ripple add/subtract cell.
//            a, b  : operand slices
//            cin   : carry-in (add) or borrow-in (sub)
//            mode  : MODE_ADD / MODE_SUB
//            res   : slice result
//            cout  : carry-out (add) or borrow-out (sub)
// Revision : 1.0 - initial release
// ============================================================================
module sub_slice
  import sub_chunk_seq_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [CHUNK-1:0] res,
  output logic             cout
);

  // Sum and difference share the same xor result bit. The propagate term
  // differs only in whether a is inverted: inverting a turns the carry
  // equation a&b | c&(a^b) into the borrow equation ~a&b | c&~(a^b).
  logic [CHUNK-1:0] w_ax;
  logic             w_c;

  assign w_ax = a ^ {CHUNK{mode == MODE_SUB}};

  always_comb begin
    res = '0;
    w_c = cin;
    for (int i = 0; i < CHUNK; i++) begin
      res[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (w_ax[i] & b[i]) | (w_c & (w_ax[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/sub_chunk_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk_seq
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,
//            LSB chunk first, carry/borrow held in a register between chunks.
//            clk, rst : clock, asynchronous active-high reset
//            bus      : sub_chunk_seq_if.slave (start/sub/A/B/bin in,
//                       busy/done/diff/bout out)
//            Optional : define SUB_CHUNK_SEQ_FLAGS_EN for zf/nf/vf outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sub_chunk_seq
  import sub_chunk_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic           clk,
  input  logic           rst,
  sub_chunk_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("sub_chunk_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_step;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_mode;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic [CHUNK-1:0]   w_a_slice;
  logic [CHUNK-1:0]   w_b_slice;
  logic [CHUNK-1:0]   w_res;
  logic               w_cout;
  logic [WIDTH-1:0]   w_diff_next;

  assign w_last = (r_cnt == CNT_W'(NCHUNK - 1));

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // A start in the done cycle chains the next operation directly.
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);

  // --------------------------------------------------------------------------
  // Datapath: one chunk per RUN cycle
  // --------------------------------------------------------------------------
  assign w_a_slice = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_b_slice = r_b[r_cnt*CHUNK +: CHUNK];

  sub_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_borrow),
    .mode (r_mode),
    .res  (w_res),
    .cout (w_cout)
  );

  // Full result as it will look after this edge; the flags on the last
  // chunk are taken from it so they see the top slice being written now.
  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[r_cnt*CHUNK +: CHUNK] = w_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= MODE_ADD;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.A;
      r_b      <= bus.B;
      r_mode   <= bus.sub;
      r_borrow <= bus.bin;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_diff   <= w_diff_next;
      r_borrow <= w_cout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_bout <= w_cout;
      end
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

`ifdef SUB_CHUNK_SEQ_FLAGS_EN
  logic r_zf;
  logic r_nf;
  logic r_vf;
  logic w_sa;
  logic w_sb;
  logic w_sr;
  logic w_vf;

  assign w_sa = r_a[WIDTH-1];
  assign w_sb = r_b[WIDTH-1];
  assign w_sr = w_diff_next[WIDTH-1];
  // Overflow only when the result sign departs from A's sign, and only for
  // the operand-sign combination that can actually leave the signed range.
  assign w_vf = (r_mode == MODE_SUB) ? ((w_sa ^ w_sb) & (w_sr ^ w_sa))
                                     : (~(w_sa ^ w_sb) & (w_sr ^ w_sa));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b0;
      r_nf <= 1'b0;
      r_vf <= 1'b0;
    end else if (w_step && w_last) begin
      r_zf <= (w_diff_next == '0);
      r_nf <= w_sr;
      r_vf <= w_vf;
    end
  end

  assign bus.zf = r_zf;
  assign bus.nf = r_nf;
  assign bus.vf = r_vf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_chunk_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_chunk_seq
// Purpose  : Self-checking bench for sub_chunk_seq. Three instances:
//            #0 WIDTH=8 CHUNK=2, #1 WIDTH=16 CHUNK=16, #2 WIDTH=12 CHUNK=3.
//            Expected results come from plain integer arithmetic.
//            Flag checks are included when SUB_CHUNK_SEQ_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_chunk_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sub_chunk_seq_if #(.WIDTH(8))  if8 ();
  sub_chunk_seq_if #(.WIDTH(16)) if16 ();
  sub_chunk_seq_if #(.WIDTH(12)) if12 ();

  sub_chunk_seq #(.WIDTH(8),  .CHUNK(2))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  sub_chunk_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  sub_chunk_seq #(.WIDTH(12), .CHUNK(3))  u_dut12 (.clk(clk), .rst(rst), .bus(if12.slave));

  logic [15:0] obs_diff [3];
  logic [2:0]  obs_done;
  logic [2:0]  obs_busy;
  logic [2:0]  obs_bout;

  assign obs_diff[0] = {8'h00, if8.diff};
  assign obs_diff[1] = if16.diff;
  assign obs_diff[2] = {4'h0, if12.diff};
  assign obs_done    = {if12.done, if16.done, if8.done};
  assign obs_busy    = {if12.busy, if16.busy, if8.busy};
  assign obs_bout    = {if12.bout, if16.bout, if8.bout};

`ifdef SUB_CHUNK_SEQ_FLAGS_EN
  logic [2:0] obs_zf;
  logic [2:0] obs_nf;
  logic [2:0] obs_vf;
  assign obs_zf = {if12.zf, if16.zf, if8.zf};
  assign obs_nf = {if12.nf, if16.nf, if8.nf};
  assign obs_vf = {if12.vf, if16.vf, if8.vf};
`endif

  function automatic int width_of(input int which);
    return (which == 0) ? 8 : (which == 1) ? 16 : 12;
  endfunction

  function automatic int nchunk_of(input int which);
    return (which == 0) ? 4 : (which == 1) ? 1 : 4;
  endfunction

  // Reference: unsigned arithmetic modulo 2^W, flags from signed range.
  task automatic model(input int which, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic bi,
                       output logic [15:0] r, output logic bo,
                       output logic z, output logic n, output logic v);
    int     w   = width_of(which);
    longint m   = longint'(1) << w;
    longint av  = longint'(a) & (m - 1);
    longint bv  = longint'(b) & (m - 1);
    longint sa  = (av >= m / 2) ? av - m : av;
    longint sb  = (bv >= m / 2) ? bv - m : bv;
    longint t;
    longint st;
    if (s) begin
      t  = av - bv - longint'(bi);
      bo = (av < bv + longint'(bi));
      st = sa - sb - longint'(bi);
    end else begin
      t  = av + bv + longint'(bi);
      bo = (t >= m);
      st = sa + sb + longint'(bi);
    end
    r = 16'(t & (m - 1));
    z = (r == 16'h0);
    n = r[w-1];
    v = (st < -(m / 2)) || (st > (m / 2 - 1));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int which, input logic st, input logic s,
                        input logic [15:0] a, input logic [15:0] b, input logic bi);
    case (which)
      0: begin if8.start = st;  if8.sub = s;  if8.A = a[7:0];   if8.B = b[7:0];   if8.bin = bi;  end
      1: begin if16.start = st; if16.sub = s; if16.A = a;       if16.B = b;       if16.bin = bi; end
      default: begin if12.start = st; if12.sub = s; if12.A = a[11:0]; if12.B = b[11:0]; if12.bin = bi; end
    endcase
  endtask

  // Called at a negedge in IDLE or DONE; returns at the first RUN negedge.
  task automatic issue(input int which, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic bi);
    set_in(which, 1'b1, s, a, b, bi);
    @(negedge clk);
    case (which)
      0:       if8.start  = 1'b0;
      1:       if16.start = 1'b0;
      default: if12.start = 1'b0;
    endcase
  endtask

  // Waits (bounded) for done, then checks result against the model.
  task automatic finish_op(input int which, input logic s, input logic [15:0] a,
                           input logic [15:0] b, input logic bi,
                           input int exp_busy, input string tag);
    logic [15:0] r;
    logic        bo, z, n, v;
    int          nb    = 0;
    int          guard = 0;
    model(which, s, a, b, bi, r, bo, z, n, v);
    while (!obs_done[which] && guard < 64) begin
      if (obs_busy[which]) nb++;
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done_seen"}, 32'(obs_done[which]), 32'd1);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_busy_low"}, 32'(obs_busy[which]), 32'd0);
    chk({tag, "_diff"}, 32'(obs_diff[which]), 32'(r));
    chk({tag, "_bout"}, 32'(obs_bout[which]), 32'(bo));
`ifdef SUB_CHUNK_SEQ_FLAGS_EN
    chk({tag, "_zf"}, 32'(obs_zf[which]), 32'(z));
    chk({tag, "_nf"}, 32'(obs_nf[which]), 32'(n));
    chk({tag, "_vf"}, 32'(obs_vf[which]), 32'(v));
`endif
  endtask

  initial begin
    logic        rs, rbi;
    logic [15:0] ra, rb, mask;
    int          ndone;

    set_in(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(2, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_busy", k), 32'(obs_busy[k]), 32'd0);
      chk($sformatf("rst%0d_done", k), 32'(obs_done[k]), 32'd0);
      chk($sformatf("rst%0d_diff", k), 32'(obs_diff[k]), 32'd0);
      chk($sformatf("rst%0d_bout", k), 32'(obs_bout[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 1: basic subtract, latency and single-cycle done
    issue(0, 1'b1, 16'h5A, 16'h3C, 1'b0);
    finish_op(0, 1'b1, 16'h5A, 16'h3C, 1'b0, 4, "t1");
    chk("t1_diff_const", 32'(obs_diff[0]), 32'h1E);
    @(negedge clk);
    chk("t1_done_pulse", 32'(obs_done[0]), 32'd0);
    chk("t1_diff_held", 32'(obs_diff[0]), 32'h1E);

    // 2, 3: borrow out and flag corners
    issue(0, 1'b1, 16'h00, 16'h01, 1'b0);
    finish_op(0, 1'b1, 16'h00, 16'h01, 1'b0, 4, "t2");
    chk("t2_diff_const", 32'(obs_diff[0]), 32'hFF);
    @(negedge clk);
    issue(0, 1'b1, 16'h80, 16'h7F, 1'b1);
    finish_op(0, 1'b1, 16'h80, 16'h7F, 1'b1, 4, "t3");
    chk("t3_diff_const", 32'(obs_diff[0]), 32'h00);
`ifdef SUB_CHUNK_SEQ_FLAGS_EN
    chk("t3_vf_const", 32'(obs_vf[0]), 32'd1);
`endif
    @(negedge clk);

    // 4: carry out, then back-to-back start in the DONE cycle
    issue(0, 1'b0, 16'hFF, 16'h01, 1'b0);
    finish_op(0, 1'b0, 16'hFF, 16'h01, 1'b0, 4, "t4a");
    chk("t4a_bout_const", 32'(obs_bout[0]), 32'd1);
    issue(0, 1'b0, 16'h10, 16'h20, 1'b0);
    chk("t4_b2b_busy", 32'(obs_busy[0]), 32'd1);
    chk("t4_b2b_done_low", 32'(obs_done[0]), 32'd0);
    finish_op(0, 1'b0, 16'h10, 16'h20, 1'b0, 4, "t4b");
    chk("t4b_diff_const", 32'(obs_diff[0]), 32'h30);
    @(negedge clk);

    // 5a: start and operand changes during RUN are ignored
    issue(0, 1'b1, 16'h5A, 16'h3C, 1'b0);
    set_in(0, 1'b1, 1'b0, 16'hFF, 16'h77, 1'b1);
    @(negedge clk);
    if8.start = 1'b0;
    finish_op(0, 1'b1, 16'h5A, 16'h3C, 1'b0, 3, "t5a");
    @(negedge clk);

    // 5b: reset mid-RUN aborts without a done pulse
    issue(0, 1'b0, 16'h33, 16'h44, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5b_busy_async", 32'(obs_busy[0]), 32'd0);
    chk("t5b_diff_async", 32'(obs_diff[0]), 32'd0);
    chk("t5b_bout_async", 32'(obs_bout[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (obs_done[0] || obs_busy[0]) ndone++;
    end
    chk("t5b_no_done", ndone, 0);
    issue(0, 1'b1, 16'hC3, 16'h3C, 1'b1);
    finish_op(0, 1'b1, 16'hC3, 16'h3C, 1'b1, 4, "t5c");
    @(negedge clk);

    // 6: single-chunk configuration
    issue(1, 1'b1, 16'h1234, 16'h1235, 1'b0);
    finish_op(1, 1'b1, 16'h1234, 16'h1235, 1'b0, 1, "t6");
    chk("t6_diff_const", 32'(obs_diff[1]), 32'hFFFF);
    chk("t6_bout_const", 32'(obs_bout[1]), 32'd1);
    @(negedge clk);

    // Random sweeps: WIDTH=12/CHUNK=3 and WIDTH=8/CHUNK=2, some back-to-back
    for (int w = 0; w < 2; w++) begin
      int which = (w == 0) ? 2 : 0;
      mask = 16'((32'd1 << width_of(which)) - 1);
      for (int k = 0; k < 24; k++) begin
        rs  = 1'($urandom);
        rbi = 1'($urandom);
        ra  = 16'($urandom) & mask;
        rb  = 16'($urandom) & mask;
        if (k % 6 == 0) ra = rb;
        issue(which, rs, ra, rb, rbi);
        finish_op(which, rs, ra, rb, rbi, nchunk_of(which), $sformatf("rnd%0d_%0d", which, k));
        if ($urandom_range(0, 1) == 0) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
